// File: rtl/mem_bus_unit.sv
// ============================================================================
//  Module   : mem_bus_unit
//  Purpose  : Memory-side bus endpoint. Holds MAR/MDR and sequences one
//             multi-cycle 16-bit SRAM read or write per request.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_unit #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              Reset_ah,
    input  logic [15:0]       Bus_Data,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Mem_Req,
    input  logic              Mem_WE,
    input  logic [15:0]       Data_from_SRAM,
    output logic [15:0]       MAR_out,
    output logic [15:0]       MDR_out,
    output logic [15:0]       Data_to_SRAM,
    output logic              Data_drive,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              CE_n,
    output logic              OE_n,
    output logic              WE_n,
    output logic              UB_n,
    output logic              LB_n,
    output logic              R,
    output logic              Busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        rw_q,    rw_d;
    logic [15:0] mar_q,   mar_d;
    logic [15:0] mdr_q,   mdr_d;

    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        CE_n       = 1'b1;
        OE_n       = 1'b1;
        WE_n       = 1'b1;
        UB_n       = 1'b1;
        LB_n       = 1'b1;
        Data_drive = 1'b0;
        R          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Loads and a request in the same cycle: the access uses the new values
                if (LD_MAR) mar_d = Bus_Data;
                if (LD_MDR) mdr_d = Bus_Data;
                if (Mem_Req) begin
                    rw_d    = Mem_WE;
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                CE_n       = 1'b0;
                UB_n       = 1'b0;
                LB_n       = 1'b0;
                OE_n       = rw_q;
                WE_n       = ~rw_q;
                Data_drive = rw_q;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    if (!rw_q) mdr_d = Data_from_SRAM;
                end
            end
            S_DONE: begin
                R          = 1'b1;
                // Keep driving write data one more cycle for SRAM hold time
                Data_drive = rw_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy         = (state_q != S_IDLE);
    assign MAR_out      = mar_q;
    assign MDR_out      = mdr_q;
    assign Data_to_SRAM = mdr_q;
    assign SRAM_ADDR    = {{(ADDR_W-16){1'b0}}, mar_q};

endmodule

`default_nettype wire
